// File: rtl/i2s_dac_tx.sv
// I2S master transmitter: parallel stereo samples in, BCLK/DACLRCK/DACDAT out. Optional I2S_UNDERRUN_CNT_EN adds underrun_cnt.
// Latency: a sample accepted in frame N is emitted in frame N+1 (MSB on that frame's second BCLK).
// Backpressure: in_ready is low while the single-entry holding register is full or the PLL is not locked.
module i2s_dac_tx #(
    parameter int SAMPLE_W    = 16,
    parameter int BCLK_HALF   = 2,
    parameter int FRAME_BCLKS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                aud_bclk,
    output logic                aud_daclrck,
    output logic                aud_dacdat,
    output logic                underrun
`ifdef I2S_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_cnt
`endif
);

    localparam int HALF  = FRAME_BCLKS / 2;
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BIT_W = $clog2(FRAME_BCLKS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BCLKS - 1);
    localparam logic [BIT_W-1:0] L_FIRST  = BIT_W'(1);
    localparam logic [BIT_W-1:0] L_LAST   = BIT_W'(SAMPLE_W);
    localparam logic [BIT_W-1:0] R_START  = BIT_W'(HALF);
    localparam logic [BIT_W-1:0] R_FIRST  = BIT_W'(HALF + 1);
    localparam logic [BIT_W-1:0] R_LAST   = BIT_W'(HALF + SAMPLE_W);

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                active;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    bit_nxt;
    logic                bclk_fall;
    logic                left_slot;
    logic                right_slot;
    logic                hold_full;
    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;
    logic [SAMPLE_W-1:0] sh_l;
    logic [SAMPLE_W-1:0] sh_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (pll_locked)  state_d = RUN;
            RUN:       if (!pll_locked) state_d = WAIT_LOCK;
            default:                    state_d = WAIT_LOCK;
        endcase
    end

    // Losing lock while in RUN clears the datapath on the very edge that leaves RUN.
    always_comb begin
        active   = 1'b0;
        in_ready = 1'b0;
        if (state_q == RUN) begin
            active   = pll_locked;
            in_ready = !hold_full;
        end
    end

    always_comb begin
        bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        bclk_fall  = (div_cnt == DIV_LAST) && aud_bclk;
        left_slot  = (bit_nxt >= L_FIRST) && (bit_nxt <= L_LAST);
        right_slot = (bit_nxt >= R_FIRST) && (bit_nxt <= R_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
            underrun    <= 1'b0;
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            sh_l        <= '0;
            sh_r        <= '0;
        end else if (!active) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
            underrun    <= 1'b0;
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            sh_l        <= '0;
            sh_r        <= '0;
        end else begin
            underrun <= 1'b0;
            if (in_valid && in_ready) begin
                hold_l    <= in_left;
                hold_r    <= in_right;
                hold_full <= 1'b1;
            end
            if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                aud_bclk <= ~aud_bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            // Data and word select move only on BCLK falling edges; slot 0 is the I2S delay bit.
            if (bclk_fall) begin
                bit_cnt     <= bit_nxt;
                aud_daclrck <= (bit_nxt >= R_START);
                if (bit_nxt == '0) begin
                    aud_dacdat <= 1'b0;
                    if (hold_full) begin
                        sh_l      <= hold_l;
                        sh_r      <= hold_r;
                        hold_full <= 1'b0;
                    end else begin
                        sh_l     <= '0;
                        sh_r     <= '0;
                        underrun <= 1'b1;
                    end
                end else if (left_slot) begin
                    aud_dacdat <= sh_l[SAMPLE_W-1];
                    sh_l       <= {sh_l[SAMPLE_W-2:0], 1'b0};
                end else if (right_slot) begin
                    aud_dacdat <= sh_r[SAMPLE_W-1];
                    sh_r       <= {sh_r[SAMPLE_W-2:0], 1'b0};
                end else begin
                    aud_dacdat <= 1'b0;
                end
            end
        end
    end

`ifdef I2S_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_cnt <= '0;
        end else if (!active) begin
            underrun_cnt <= '0;
        end else if (bclk_fall && (bit_nxt == '0) && !hold_full && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: lock sequencing, frame timing, data order, underrun and relock flush.
module tb_i2s_dac_tx;

    logic        clk;
    logic        rst;
    logic        pll_locked;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;
    logic        underrun;
`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int   compared   = 0;
    int   mismatched = 0;
    int   rdy_falls  = 0;
    logic rdy_prev   = 1'b0;

    localparam logic [15:0] STREAM_L [8] = '{16'h8000, 16'h0001, 16'hFFFF, 16'h1234,
                                             16'h5A5A, 16'h7FFF, 16'hC3A5, 16'h0F0F};
    localparam logic [15:0] STREAM_R [8] = '{16'h0002, 16'h4000, 16'hAAAA, 16'h5555,
                                             16'hFEDC, 16'h8001, 16'h1357, 16'hF00F};

    i2s_dac_tx #(
        .SAMPLE_W    (16),
        .BCLK_HALF   (2),
        .FRAME_BCLKS (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_left     (in_left),
        .in_right    (in_right),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat),
        .underrun    (underrun)
`ifdef I2S_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rdy_prev && !in_ready) rdy_falls++;
        rdy_prev = in_ready;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Capture one frame starting just after its bit-0 falling edge; returns at the next one.
    task automatic capture_frame(output logic [15:0] l, output logic [15:0] r,
                                 output int others, output int pulses);
        int   slot;
        int   guard;
        logic prev_bclk;
        logic done;
        l = '0; r = '0; others = 0; pulses = 0;
        slot = 0; guard = 0; done = 1'b0;
        prev_bclk = aud_bclk;
        while (!done && guard < 400) begin
            @(negedge clk);
            guard++;
            if (underrun === 1'b1) pulses++;
            if (!prev_bclk && aud_bclk) begin
                if (slot >= 1 && slot <= 16)       l = {l[14:0], aud_dacdat};
                else if (slot >= 33 && slot <= 48) r = {r[14:0], aud_dacdat};
                else if (aud_dacdat !== 1'b0)      others++;
                slot++;
            end
            if (prev_bclk && !aud_bclk && slot == 64) done = 1'b1;
            prev_bclk = aud_bclk;
        end
        if (!done) begin
            compared++; mismatched++;
            $display("FAIL capture_timeout: saw %0d bclk rises, required 64", slot);
        end
    endtask

    task automatic test_reset();
        int         bad;
        int         n;
        logic [7:0] bpat;
        rst = 1'b0; pll_locked = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
        repeat (3) @(negedge clk);
        compared++;
        if ({aud_bclk, aud_daclrck, aud_dacdat, underrun, in_ready} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b required 00000", {aud_bclk, aud_daclrck, aud_dacdat, underrun, in_ready});
        end
`ifdef I2S_UNDERRUN_CNT_EN
        compared++;
        if (underrun_cnt !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_cnt: got %0d required 0", underrun_cnt);
        end
`endif
        rst = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({aud_bclk, aud_daclrck, aud_dacdat, underrun, in_ready} !== 5'b0) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL wait_lock_idle: got %0d active cycles required 0", bad);
        end
        pll_locked = 1'b1;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL ready_before_lock: got %b required 0", in_ready);
        end
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_after_lock: got %b required 1", in_ready);
        end
        bpat = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bpat = {bpat[6:0], aud_bclk};
        end
        compared++;
        if (bpat !== 8'b01100110) begin
            mismatched++;
            $display("FAIL bclk_pattern: got %b required 01100110", bpat);
        end
        n = 8;
        while (aud_daclrck !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        compared++;
        if (n !== 128) begin
            mismatched++;
            $display("FAIL lrck_first_rise: got %0d cycles required 128", n);
        end
        n = 0;
        while (aud_daclrck !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        while (aud_daclrck !== 1'b1 && n < 800) begin @(negedge clk); n++; end
        compared++;
        if (n !== 256) begin
            mismatched++;
            $display("FAIL lrck_period: got %0d cycles required 256", n);
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] l, r;
        int          others, pulses, guard;
        logic        prev, urun, seen;
        in_left = 16'hA5C3; in_right = 16'h0F01; in_valid = 1'b1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL single_ready: got %b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; in_left = '0; in_right = '0;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL single_held: in_ready got %b required 0", in_ready);
        end
        prev = aud_daclrck; seen = 1'b0; urun = 1'b0; guard = 0;
        while (!seen && guard < 400) begin
            @(negedge clk);
            guard++;
            if (prev && !aud_daclrck) begin seen = 1'b1; urun = underrun; end
            prev = aud_daclrck;
        end
        compared++;
        if (!seen || urun !== 1'b0) begin
            mismatched++;
            $display("FAIL single_boundary: seen %b underrun %b required seen 1 underrun 0", seen, urun);
        end
        capture_frame(l, r, others, pulses);
        compared++;
        if (l !== 16'hA5C3) begin mismatched++; $display("FAIL single_left: got %h required a5c3", l); end
        compared++;
        if (r !== 16'h0F01) begin mismatched++; $display("FAIL single_right: got %h required 0f01", r); end
        compared++;
        if (others !== 0) begin mismatched++; $display("FAIL single_idle_slots: got %0d ones required 0", others); end
        compared++;
        if (pulses !== 1) begin mismatched++; $display("FAIL single_next_underrun: got %0d required 1", pulses); end
    endtask

    task automatic test_back_to_back();
        int sent;
        int falls0;
        falls0 = rdy_falls;
        sent = 0;
        fork
            begin
                int guard;
                guard = 0;
                while (sent < 8 && guard < 3000) begin
                    in_valid = 1'b1;
                    in_left  = STREAM_L[sent];
                    in_right = STREAM_R[sent];
                    if (in_ready === 1'b1) sent++;
                    @(negedge clk);
                    guard++;
                end
                in_valid = 1'b0;
            end
            begin
                logic [15:0] l, r;
                int          others, pulses;
                capture_frame(l, r, others, pulses);
                compared++;
                if (pulses !== 0) begin mismatched++; $display("FAIL stream_start_underrun: got %0d required 0", pulses); end
                for (int k = 0; k < 8; k++) begin
                    capture_frame(l, r, others, pulses);
                    compared++;
                    if (l !== STREAM_L[k] || r !== STREAM_R[k]) begin
                        mismatched++;
                        $display("FAIL stream_data[%0d]: got %h/%h required %h/%h", k, l, r, STREAM_L[k], STREAM_R[k]);
                    end
                    compared++;
                    if (others !== 0 || pulses !== ((k == 7) ? 1 : 0)) begin
                        mismatched++;
                        $display("FAIL stream_frame[%0d]: stray ones %0d underruns %0d required 0 and %0d", k, others, pulses, (k == 7) ? 1 : 0);
                    end
                end
            end
        join
        compared++;
        if (sent !== 8) begin mismatched++; $display("FAIL stream_sent: got %0d required 8", sent); end
        compared++;
        if (rdy_falls - falls0 !== 8) begin
            mismatched++;
            $display("FAIL stream_ready_drops: got %0d required 8", rdy_falls - falls0);
        end
    endtask

    task automatic test_load_collision();
        logic [15:0] l, r;
        int          others, pulses;
        repeat (255) @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || aud_daclrck !== 1'b1) begin
            mismatched++;
            $display("FAIL collision_setup: ready %b lrck %b required 1 1", in_ready, aud_daclrck);
        end
        in_valid = 1'b1; in_left = 16'h3C5A; in_right = 16'hE781;
        @(negedge clk);
        in_valid = 1'b0;
        compared++;
        if (underrun !== 1'b1) begin mismatched++; $display("FAIL collision_underrun: got %b required 1", underrun); end
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL collision_stored: in_ready got %b required 0", in_ready); end
        capture_frame(l, r, others, pulses);
        compared++;
        if ({l, r} !== 32'h0 || others !== 0 || pulses !== 0) begin
            mismatched++;
            $display("FAIL collision_silent_frame: got %h/%h ones %0d underruns %0d required 0", l, r, others, pulses);
        end
        capture_frame(l, r, others, pulses);
        compared++;
        if (l !== 16'h3C5A || r !== 16'hE781) begin
            mismatched++;
            $display("FAIL collision_data: got %h/%h required 3c5a/e781", l, r);
        end
        compared++;
        if (pulses !== 1) begin mismatched++; $display("FAIL collision_after: underruns %0d required 1", pulses); end
    endtask

    task automatic test_relock();
        int bad;
        int n;
        in_valid = 1'b1; in_left = 16'h7E81; in_right = 16'h1818;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL relock_ready: got %b required 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (aud_daclrck !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        repeat (40) @(negedge clk);
        compared++;
        if (aud_daclrck !== 1'b1 || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL relock_pending: lrck %b ready %b required 1 0", aud_daclrck, in_ready);
        end
        pll_locked = 1'b0;
        @(negedge clk);
        compared++;
        if ({aud_bclk, aud_daclrck, aud_dacdat, underrun, in_ready} !== 5'b0) begin
            mismatched++;
            $display("FAIL unlock_outputs: got %b required 00000", {aud_bclk, aud_daclrck, aud_dacdat, underrun, in_ready});
        end
`ifdef I2S_UNDERRUN_CNT_EN
        compared++;
        if (underrun_cnt !== 16'd0) begin mismatched++; $display("FAIL unlock_cnt: got %0d required 0", underrun_cnt); end
`endif
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if ({aud_bclk, aud_daclrck, aud_dacdat, underrun, in_ready} !== 5'b0) bad++;
        end
        compared++;
        if (bad !== 0) begin mismatched++; $display("FAIL unlock_idle: got %0d active cycles required 0", bad); end
        pll_locked = 1'b1;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL relock_flushed: in_ready got %b required 1", in_ready); end
    endtask

    task automatic test_underrun_idle();
        logic [15:0] l, r;
        int          others, pulses, total;
        total = 0;
        for (int k = 0; k < 3; k++) begin
            capture_frame(l, r, others, pulses);
            compared++;
            if ({l, r} !== 32'h0 || others !== 0) begin
                mismatched++;
                $display("FAIL idle_data[%0d]: got %h/%h ones %0d required 0", k, l, r, others);
            end
            compared++;
            if (pulses !== 1) begin mismatched++; $display("FAIL idle_underrun[%0d]: got %0d required 1", k, pulses); end
            total += pulses;
        end
        compared++;
        if (total !== 3) begin mismatched++; $display("FAIL idle_total: got %0d required 3", total); end
`ifdef I2S_UNDERRUN_CNT_EN
        compared++;
        if (underrun_cnt !== 16'd3) begin mismatched++; $display("FAIL idle_cnt: got %0d required 3", underrun_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_load_collision();
        test_relock();
        test_underrun_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- I2S master transmitter for the audio codec DAC path. Runs on the 12 MHz PLL output.
- Generates BCLK, DACLRCK and DACDAT from a parallel stereo sample stream supplied through a valid/ready handshake.
- Sits directly downstream of the 12 MHz clock generator. Held idle until the PLL reports lock.
- The codec is configured over I2C (by the Raspberry Pi) as an I2S slave with a matching word length.

Parameters:
- SAMPLE_W, 16, bits per channel sample (8..FRAME_BCLKS/2-1).
- BCLK_HALF, 2, clk cycles per BCLK half-period (>=1).
- FRAME_BCLKS, 64, BCLK periods per stereo frame (even, >= 2*SAMPLE_W+2).

Ports:
- clk  in  1  12 MHz clock from PLL outclk_0
- rst  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock indicator, asynchronous to nothing (same domain)
- in_valid  in  1  stereo sample present
- in_ready  out  1  holding register can accept a sample
- in_left  in  SAMPLE_W  left sample, two's complement
- in_right  in  SAMPLE_W  right sample, two's complement
- aud_bclk  out  1  I2S bit clock
- aud_daclrck  out  1  word select: 0 = left, 1 = right
- aud_dacdat  out  1  serial data, MSB first
- underrun  out  1  one-cycle pulse: frame started with no sample held

Behaviour:
- Reset (rst=0): state WAIT_LOCK. aud_bclk=0, aud_daclrck=0, aud_dacdat=0, in_ready=0, underrun=0. Counters zero, holding register empty, shift registers zero.
- WAIT_LOCK: outputs held at reset values.
  - Goes to RUN on the first clk cycle with pll_locked=1. in_ready asserts in that same transition cycle.
  - pll_locked=0 in RUN: return to WAIT_LOCK next cycle. Outputs return to reset values, counters clear, holding register is flushed (pending sample discarded).
- Divider: div_cnt counts 0..BCLK_HALF-1. At terminal count, aud_bclk toggles.
- Falling-edge event (aud_bclk 1->0):
  - bit_cnt advances 0..FRAME_BCLKS-1 and wraps.
  - aud_daclrck = (bit_cnt >= FRAME_BCLKS/2).
- The first BCLK period after RUN entry is treated as bit_cnt=0.
- Data timing (I2S, one-BCLK delay):
  - Left slot: in slot k = bit_cnt for left, bit_cnt-FRAME_BCLKS/2 for right, aud_dacdat = sample[SAMPLE_W-k] for 1<=k<=SAMPLE_W, else 0.
  - aud_dacdat changes only on BCLK falling edges; the codec samples on rising edges.
- Frame load, on the falling edge entering bit_cnt=0:
  - If the holding register is full: copy both channels into the shift registers and mark the register empty.
  - If empty: load zeros and pulse underrun for one clk.
- Handshake:
  - in_ready = RUN && holding register empty.
  - Transfer occurs when in_valid && in_ready at a clk edge.
  - Inputs are sampled only on transfer. in_valid may be held while in_ready=0; nothing is lost.
- Simultaneous frame load and transfer in the same cycle: the load sees the register empty and underruns. The transferred sample is stored and played in the next frame.
- Latency: a sample accepted during frame N is emitted in frame N+1, MSB on the second BCLK of that frame.
- Throughput: one sample per frame. Frame rate = clk / (2*BCLK_HALF*FRAME_BCLKS); defaults give 46.875 kHz.

Optional Feature:
- Macro I2S_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt (16 bits). It increments on each underrun pulse, saturates at 0xFFFF, and clears on reset or WAIT_LOCK entry.
- Undefined: port and logic absent; underrun pulse still present.

Test Plan:
- Reset release with pll_locked=0 for 1000 clk -> all outputs 0, in_ready=0. Raise pll_locked -> in_ready=1 next cycle, aud_bclk period 4 clk, aud_daclrck period 256 clk.
- Send left=16'hA5C3, right=16'h0F01 before the first frame boundary -> next frame: left slot bits 1..16 read A5C3 MSB first, right slot reads 0F01, remaining slots 0, no underrun.
- Continuous stream of 8 sample pairs, in_valid always 1 -> each sample appears exactly once in order, in_ready drops once per frame, no underrun.
- No input for 3 frames -> aud_dacdat constant 0, underrun pulses 3 times; with I2S_UNDERRUN_CNT_EN, underrun_cnt=3.
- Present a sample in the exact cycle of the frame-load edge -> underrun pulse that frame, sample emitted in the following frame.
- Drop pll_locked mid-right-slot with a sample pending -> WAIT_LOCK next cycle, outputs 0. Relock -> first frame underruns (pending sample flushed).
